// File: rtl/minisys_pkg.sv
// Shared MiniSys-1 definitions: register numbers, instruction field slices
// and the writeback-stage state encoding.
package minisys_pkg;

    // Architectural register numbers with special meaning.
    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Instruction word field positions.
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    // Writeback stage states: IDLE accepts work, MEM waits on a load.
    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_unit32.sv
// Writeback/commit stage for MiniSys-1: accepts one executed instruction at a
// time, performs the load read (with timeout) when needed, and drives a single
// registered write into the decode-stage register file.
module writeback_unit32
    import minisys_pkg::*;
#(
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic        in_jal,
    input  logic        in_regdst,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pcplus4,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic        busy,
    output logic        err
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_t         state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              mem_req_q,  mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              rf_we_q,    rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic [4:0]        dest_q,     dest_d;
    logic              err_q,      err_d;

    logic              accept;
    logic              is_load;
    logic [4:0]        dest;

    // Opcode/funct/rs bits are decoded upstream; only rt and rd matter here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{in_instruction[31:21], in_instruction[10:0]};

    // Handshake and status come straight from the state register only.
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == MEM);
    assign accept   = in_valid && in_ready;

    // Destination select and load detection, mirroring the decode-stage mux.
    assign dest    = in_jal    ? REG_RA
                   : in_regdst ? in_instruction[RD_HI:RD_LO]
                   :             in_instruction[RT_HI:RT_LO];
    assign is_load = in_memtoreg && in_regwrite && !in_jal;

    // Next-state and next-output logic for the IDLE/MEM sequencer.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        dest_d     = dest_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                // mem_ack is deliberately ignored here.
                if (accept) begin
                    dest_d = dest;
                    if (is_load) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = in_alu_result;
                        cnt_d      = '0;
                        state_d    = MEM;
                    end else begin
                        rf_we_d    = in_regwrite && (dest != REG_ZERO);
                        rf_waddr_d = dest;
                        rf_wdata_d = in_jal ? in_pcplus4 : in_alu_result;
                    end
                end
            end

            MEM: begin
                // Ack takes priority over the timeout on the final cycle.
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    rf_we_d    = (dest_q != REG_ZERO);
                    rf_waddr_d = dest_q;
                    rf_wdata_d = mem_rdata;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d  = 1'b0;
                    rf_we_d    = (dest_q != REG_ZERO);
                    rf_waddr_d = dest_q;
                    rf_wdata_d = TIMEOUT_DATA;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            dest_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            dest_q     <= dest_d;
            err_q      <= err_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_writeback_unit32.sv
// Self-checking bench for writeback_unit32: directed scenarios followed by
// randomized instructions, each checked against a transaction-level model.
module tb_writeback_unit32;

    localparam int          TIMEOUT      = 4;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic        in_jal;
    logic        in_regdst;
    logic [31:0] in_alu_result;
    logic [31:0] in_pcplus4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_err = 1'b0;

    writeback_unit32 #(
        .TIMEOUT      (TIMEOUT),
        .TIMEOUT_DATA (TIMEOUT_DATA)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_regwrite    (in_regwrite),
        .in_memtoreg    (in_memtoreg),
        .in_jal         (in_jal),
        .in_regdst      (in_regdst),
        .in_alu_result  (in_alu_result),
        .in_pcplus4     (in_pcplus4),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy),
        .err            (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One instruction end to end. lat = cycle of the MEM wait in which the
    // memory acks (1..TIMEOUT); 0 means no ack at all, so the load times out.
    task automatic run_op(input logic rw, input logic mtr, input logic jal, input logic rdst,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4, input int lat);
        logic [4:0]  dest;
        logic        load;
        logic [31:0] rdata;
        logic [31:0] instr;
        logic        acked;
        instr        = $urandom;
        instr[20:16] = rt;
        instr[15:11] = rd;
        dest  = jal ? 5'd31 : (rdst ? rd : rt);
        load  = mtr && rw && !jal;

        @(negedge clock);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_regwrite    = rw;
        in_memtoreg    = mtr;
        in_jal         = jal;
        in_regdst      = rdst;
        in_alu_result  = alu;
        in_pcplus4     = pc4;
        check("ready_before_accept", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;

        if (!load) begin
            check("nl_rf_we",    rf_we,    rw && (dest != 5'd0));
            check("nl_rf_waddr", rf_waddr, dest);
            check("nl_rf_wdata", rf_wdata, jal ? pc4 : alu);
            check("nl_mem_req",  mem_req,  0);
            check("nl_ready",    in_ready, 1);
        end else begin
            check("ld_req",      mem_req,  1);
            check("ld_addr",     mem_addr, alu);
            check("ld_busy",     busy,     1);
            check("ld_ready",    in_ready, 0);
            check("ld_rf_we",    rf_we,    0);
            for (int k = 1; k <= TIMEOUT; k++) begin
                @(negedge clock);
                acked     = (k == lat);
                rdata     = $urandom;
                mem_ack   = acked;
                mem_rdata = rdata;
                @(posedge clock);
                #1;
                mem_ack = 1'b0;
                if (acked || k == TIMEOUT) begin
                    if (!acked) exp_err = 1'b1;
                    check("done_req",      mem_req,  0);
                    check("done_rf_we",    rf_we,    dest != 5'd0);
                    check("done_rf_waddr", rf_waddr, dest);
                    check("done_rf_wdata", rf_wdata, acked ? rdata : TIMEOUT_DATA);
                    check("done_ready",    in_ready, 1);
                    check("done_busy",     busy,     0);
                    break;
                end else begin
                    check("wait_req",   mem_req,  1);
                    check("wait_addr",  mem_addr, alu);
                    check("wait_rf_we", rf_we,    0);
                    check("wait_busy",  busy,     1);
                end
            end
        end
        check("err", err, exp_err);
    endtask

    // One cycle with nothing offered: any previous write pulse must be gone.
    task automatic idle_cycle(input logic stray_ack);
        @(negedge clock);
        mem_ack   = stray_ack;
        mem_rdata = $urandom;
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        check("idle_rf_we",   rf_we,   0);
        check("idle_mem_req", mem_req, 0);
        check("idle_ready",   in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_regwrite    = 1'b0;
        in_memtoreg    = 1'b0;
        in_jal         = 1'b0;
        in_regdst      = 1'b0;
        in_alu_result  = '0;
        in_pcplus4     = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_req",  mem_req,  0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rf_we",    rf_we,    0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_busy",     busy,     0);
        check("rst_err",      err,      0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);

        // R-type adds back to back, then the pulse must drop.
        run_op(1, 0, 0, 1, 5'd3, 5'd5, 32'h1234, 32'h0, 0);
        run_op(1, 0, 0, 1, 5'd3, 5'd6, 32'h5678, 32'h0, 0);
        idle_cycle(0);

        // jal, and jal with memtoreg set (must not touch memory).
        run_op(1, 0, 1, 1, 5'd2, 5'd7, 32'h9999, 32'h0000_0048, 0);
        run_op(1, 1, 1, 0, 5'd2, 5'd7, 32'h9999, 32'h0000_0100, 0);

        // lw rt=8, ack on the third wait cycle; then ack on the final cycle.
        run_op(1, 1, 0, 0, 5'd8, 5'd0, 32'hC000_0010, 32'h0, 3);
        run_op(1, 1, 0, 0, 5'd9, 5'd0, 32'hC000_0020, 32'h0, TIMEOUT);

        // Writes to $0 suppressed; memtoreg without regwrite is a no-op.
        run_op(1, 0, 0, 1, 5'd4, 5'd0, 32'hAAAA, 32'h0, 0);
        run_op(0, 1, 0, 0, 5'd10, 5'd0, 32'hC000_0030, 32'h0, 1);
        idle_cycle(0);

        // Timeout sets the sticky error; a later good load leaves it set.
        run_op(1, 1, 0, 0, 5'd11, 5'd0, 32'hC000_0040, 32'h0, 0);
        run_op(1, 1, 0, 0, 5'd12, 5'd0, 32'hC000_0050, 32'h0, 1);
        idle_cycle(0);

        // Reset during the second cycle of a MEM wait abandons the load.
        @(negedge clock);
        in_valid       = 1'b1;
        in_instruction = 32'h0;
        in_instruction[20:16] = 5'd13;
        in_regwrite    = 1'b1;
        in_memtoreg    = 1'b1;
        in_jal         = 1'b0;
        in_regdst      = 1'b0;
        in_alu_result  = 32'hC000_0060;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset   = 1'b0;
        exp_err = 1'b0;
        check("abort_req",   mem_req,  0);
        check("abort_rf_we", rf_we,    0);
        check("abort_busy",  busy,     0);
        check("abort_ready", in_ready, 1);
        check("abort_err",   err,      0);
        idle_cycle(1);

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) begin
            run_op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom_range(0, TIMEOUT));
            if ($urandom_range(0, 4) == 0) idle_cycle($urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit32.md
# writeback_unit32

Writeback/commit stage for the MiniSys-1 32-bit CPU: the producer side of the register-file write port. It accepts one executed instruction at a time from the execute stage through a valid/ready handshake. For loads, it performs the data-RAM/IO read with a req/ack handshake and a timeout. It then drives a single registered write (enable, 5-bit address, 32-bit data) into the 32×32 register file, selecting the destination and data exactly as the decode-stage writeback mux expects.

## Interface
- TIMEOUT, 255: max cycles spent waiting for mem_ack before abandoning a load (1..65535).
- TIMEOUT_DATA, 32'h0000_0000: value written to the destination register on load timeout.

Reset reset, synchronous, active-high; clock clock.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  execute result valid
- in_ready  out  1  unit can accept this cycle
- in_instruction  in  32  instruction word; rt=[20:16], rd=[15:11]
- in_regwrite  in  1  instruction writes a register
- in_memtoreg  in  1  result comes from memory/IO (load)
- in_jal  in  1  jal: dest $31, data = in_pcplus4
- in_regdst  in  1  1: dest rd, 0: dest rt
- in_alu_result  in  32  ALU result / load address
- in_pcplus4  in  32  link value for jal
- mem_req  out  1  load read request, held until ack
- mem_addr  out  32  load address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read data
- rf_we  out  1  register-file write strobe (one cycle)
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- busy  out  1  load outstanding (state MEM)
- err  out  1  sticky: a load timed out

## Operation
- States: IDLE, MEM.
- Transfer occurs when in_valid && in_ready.
- in_ready = (state == IDLE).
- Destination: in_jal → 31; else in_regdst → rd; else rt. The destination is latched at accept.
- Data priority: jal → in_pcplus4; else load → memory data; else in_alu_result.
- Load = in_memtoreg && in_regwrite && !in_jal. in_memtoreg with in_regwrite=0 is a non-load: no memory access, no write.
- IDLE, accepting a non-load: the next edge sets rf_we = in_regwrite && (dest ≠ 0), with rf_waddr/rf_wdata loaded. State stays IDLE.
- IDLE, accepting a load: the next edge sets mem_req=1, mem_addr=in_alu_result, clears the timeout counter, and moves to MEM. rf_we=0.
- MEM, mem_ack=1:
  - next edge: mem_req=0, rf_wdata=mem_rdata, rf_we=(dest ≠ 0), state → IDLE.
- MEM, no ack:
  - counter increments.
  - When the counter reaches TIMEOUT-1 without ack, the next edge sets mem_req=0, rf_wdata=TIMEOUT_DATA, rf_we=(dest ≠ 0), err=1, state → IDLE.
- Timeout boundary: ack arriving in the same cycle the counter hits TIMEOUT-1 wins; no error is flagged.
- Writes to $0 are always suppressed (rf_we stays 0); rf_waddr/rf_wdata still update.
- mem_ack in IDLE is ignored.
- err is cleared only by reset.

## Timing
- Reset values: state IDLE, in_ready=1 (after reset deasserts), mem_req=0, mem_addr=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, err=0, counter=0.
- A reset asserted mid-load abandons it with no write.
- rf_we is a single-cycle pulse, registered.
- Non-load latency: accept at edge N → rf_we high in cycle N+1. Throughput is one per cycle with back-to-back accepts.
- Load latency: accept at edge N → mem_req high from cycle N+1. ack sampled at edge M → rf_we high in cycle M+1 with in_ready=1 again. Minimum total is 2 cycles (ack in the first req cycle).
- mem_addr is stable while mem_req=1.
- busy == (state == MEM).
- Combinational paths are limited to in_ready and busy from state; no input-to-output combinational path.

## Structure
- Shared package minisys_pkg holds:
  - REG_RA = 5'd31, REG_ZERO = 5'd0
  - the wb_state_t enum {IDLE, MEM}
  - instruction field-slice constants (RT_HI/LO, RD_HI/LO)
- The register file lives in the decode stage; this block only drives its write port.
- No sub-module: the FSM and timeout counter stay inline.
- Counter width is $clog2(TIMEOUT+1).

## Test plan
- R-type add: rd=5, alu_result=32'h1234 accepted at edge 1 → rf_we=1, rf_waddr=5, rf_wdata=32'h1234 in cycle 2. Repeating back-to-back with rd=6 → pulse in cycle 3.
- jal: in_pcplus4=32'h0000_0048, regdst=1 → rf_waddr=31, rf_wdata=32'h48. With jal=1 and memtoreg=1 → no mem_req.
- lw: rt=8, alu_result=32'hC000_0010, ack after 3 cycles with rdata=32'hCAFE_F00D → mem_addr=32'hC000_0010, in_ready=0 while busy, rf_we one cycle after ack with rf_wdata=32'hCAFE_F00D, err=0.
- Timeout with TIMEOUT=4 and no ack → req high 4 cycles, then rf_we with rf_wdata=TIMEOUT_DATA and err=1 (sticky). Ack on the 4th cycle → normal write, err=0.
- Write to $0 (rd=0, regwrite=1) → rf_we stays 0. memtoreg=1 with regwrite=0 → no mem_req, no write.
- Reset in cycle 2 of a MEM wait → mem_req=0, rf_we=0, busy=0, in_ready=1 next cycle. A later stray mem_ack in IDLE → no write.
